// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM encodings,
// the PC increment and the default reset address.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam int          PC_INCR          = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Next-PC priority select: pending redirect > branch > jr > jump > pc4.
// Redirect targets are word-aligned on the way out.
module pc_next_mux #(
  parameter int BITS_SIZE = 32
) (
  input  logic                 pend_valid,
  input  logic [BITS_SIZE-1:0] pend_addr,
  input  logic                 branch_taken,
  input  logic [BITS_SIZE-1:0] branch_addr,
  input  logic                 jr,
  input  logic [BITS_SIZE-1:0] jr_addr,
  input  logic                 jump,
  input  logic [BITS_SIZE-1:0] jump_addr,
  input  logic [BITS_SIZE-1:0] pc4,
  output logic [BITS_SIZE-1:0] next_pc,
  output logic                 redirect
);

  localparam logic [BITS_SIZE-1:0] ALIGN_MASK = ~BITS_SIZE'(3);

  always_comb begin
    next_pc  = pc4;
    redirect = 1'b0;
    if (pend_valid) begin
      next_pc  = pend_addr & ALIGN_MASK;
      redirect = 1'b1;
    end else if (branch_taken) begin
      next_pc  = branch_addr & ALIGN_MASK;
      redirect = 1'b1;
    end else if (jr) begin
      next_pc  = jr_addr & ALIGN_MASK;
      redirect = 1'b1;
    end else if (jump) begin
      next_pc  = jump_addr & ALIGN_MASK;
      redirect = 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage program counter owner: run/step/halt FSM, PC register and a
// one-deep pending-redirect register that holds a target across stalls.
//
// state   | meaning
// IDLE    | PC frozen, waiting for start or step from the debug unit
// RUN     | PC advances on every non-stalled cycle
// STEP    | as RUN, returns to IDLE after one PC update
// HALT    | HALT decoded; frozen until reset
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int                   BITS_SIZE = 32,
  parameter logic [BITS_SIZE-1:0] RESET_PC  = BITS_SIZE'(RESET_PC_DEFAULT)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start,
  input  logic                 i_step,
  input  logic                 i_halt_detected,
  input  logic                 i_stall,
  input  logic                 i_branch_taken,
  input  logic [BITS_SIZE-1:0] i_branch_addr,
  input  logic                 i_jr,
  input  logic [BITS_SIZE-1:0] i_jr_addr,
  input  logic                 i_jump,
  input  logic [BITS_SIZE-1:0] i_jump_addr,
  output logic [BITS_SIZE-1:0] o_pc,
  output logic [BITS_SIZE-1:0] o_pc4,
  output logic                 o_pc_valid,
  output logic                 o_flush_ifid,
  output logic [1:0]           o_state
);

  state_t               state_q;
  logic                 pend_valid_q;
  logic [BITS_SIZE-1:0] pend_addr_q;
  logic [BITS_SIZE-1:0] next_pc;
  logic                 redirect;
  logic                 active;

  assign active = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign o_pc4  = o_pc + BITS_SIZE'(PC_INCR);

  pc_next_mux #(.BITS_SIZE(BITS_SIZE)) u_next_mux (
    .pend_valid   (pend_valid_q),
    .pend_addr    (pend_addr_q),
    .branch_taken (i_branch_taken),
    .branch_addr  (i_branch_addr),
    .jr           (i_jr),
    .jr_addr      (i_jr_addr),
    .jump         (i_jump),
    .jump_addr    (i_jump_addr),
    .pc4          (o_pc4),
    .next_pc      (next_pc),
    .redirect     (redirect)
  );

  assign o_pc_valid   = active && !i_stall;
  assign o_flush_ifid = active && !i_stall && !i_halt_detected && redirect;
  assign o_state      = state_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= ST_IDLE;
      o_pc         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start)     state_q <= ST_RUN;
          else if (i_step) state_q <= ST_STEP;
        end
        ST_RUN, ST_STEP: begin
          if (i_halt_detected) begin
            state_q <= ST_HALT;
          end else if (i_stall) begin
            // only the oldest redirect is kept; mux output is the new target here
            if (redirect && !pend_valid_q) begin
              pend_valid_q <= 1'b1;
              pend_addr_q  <= next_pc;
            end
          end else begin
            o_pc         <= next_pc;
            pend_valid_q <= 1'b0;
            if (state_q == ST_STEP) state_q <= ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 0, step = 0, halt = 0, stall = 0;
  logic        br = 0, jr = 0, jmp = 0;
  logic [31:0] br_addr = 0, jr_addr = 0, jmp_addr = 0;
  logic [31:0] pc, pc4;
  logic        pc_valid, flush;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  // reference model
  int          m_state;
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];

  // last sampled DUT outputs
  logic [31:0] s_pc;
  logic        s_valid, s_flush;
  logic [1:0]  s_state;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_start         (start),
    .i_step          (step),
    .i_halt_detected (halt),
    .i_stall         (stall),
    .i_branch_taken  (br),
    .i_branch_addr   (br_addr),
    .i_jr            (jr),
    .i_jr_addr       (jr_addr),
    .i_jump          (jmp),
    .i_jump_addr     (jmp_addr),
    .o_pc            (pc),
    .o_pc4           (pc4),
    .o_pc_valid      (pc_valid),
    .o_flush_ifid    (flush),
    .o_state         (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'h0;
    m_pend.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    {start, step, halt, stall, br, jr, jmp} = '0;
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_valid", {31'd0, pc_valid}, 32'd0);
    check("rst_flush", {31'd0, flush}, 32'd0);
    model_reset();
    #2 rst_n = 1'b1;
  endtask

  // drive one cycle of inputs, compare against the model, then advance the model
  task automatic cyc(input logic a_start, input logic a_step, input logic a_halt,
                     input logic a_stall, input logic a_br, input logic [31:0] a_ba,
                     input logic a_jr, input logic [31:0] a_jra,
                     input logic a_j, input logic [31:0] a_ja);
    logic        act, redir, exp_flush;
    logic [31:0] tgt;
    @(negedge clk);
    start = a_start; step = a_step; halt = a_halt; stall = a_stall;
    br = a_br; br_addr = a_ba; jr = a_jr; jr_addr = a_jra; jmp = a_j; jmp_addr = a_ja;
    #1;
    s_pc = pc; s_valid = pc_valid; s_flush = flush; s_state = state;

    act       = (m_state == 1) || (m_state == 2);
    redir     = a_br || a_jr || a_j;
    tgt       = a_br ? a_ba : (a_jr ? a_jra : a_ja);
    tgt       = {tgt[31:2], 2'b00};
    exp_flush = act && !a_stall && !a_halt && (m_pend.size() > 0 || redir);

    check("pc", pc, m_pc);
    check("pc4", pc4, m_pc + 32'd4);
    check("state", {30'd0, state}, m_state);
    check("valid", {31'd0, pc_valid}, {31'd0, act && !a_stall});
    check("flush", {31'd0, flush}, {31'd0, exp_flush});

    if (m_state == 0) begin
      if (a_start)     m_state = 1;
      else if (a_step) m_state = 2;
    end else if (act) begin
      if (a_halt) m_state = 3;
      else if (a_stall) begin
        if (redir && m_pend.size() == 0) m_pend.push_back(tgt);
      end else begin
        if (m_pend.size() > 0) m_pc = m_pend.pop_front();
        else if (redir)        m_pc = tgt;
        else                   m_pc = m_pc + 32'd4;
        if (m_state == 2) m_state = 0;
      end
    end
  endtask

  task automatic idle_cyc(input logic a_stall);
    cyc(0, 0, 0, a_stall, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // sequential run from reset
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_state", {30'd0, s_state}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle_cyc(0);
      check("seq_pc", s_pc, 32'(i * 4));
      check("seq_valid", {31'd0, s_valid}, 32'd1);
    end

    // jump
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0100);
    check("jmp_pc", s_pc, 32'h10);
    check("jmp_flush", {31'd0, s_flush}, 32'd1);
    idle_cyc(0);
    check("jmp_tgt", s_pc, 32'h0040_0100);

    // branch beats jump
    cyc(0, 0, 0, 0, 1, 32'h200, 0, 0, 1, 32'h300);
    idle_cyc(0);
    check("br_prio", s_pc, 32'h200);

    // redirect held across stall, older one wins
    cyc(0, 0, 0, 1, 0, 0, 1, 32'h88, 0, 0);
    check("stall_flush", {31'd0, s_flush}, 32'd0);
    cyc(0, 0, 0, 1, 0, 0, 1, 32'h88, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 1, 32'h99);
    check("stall_hold", s_pc, 32'h204);
    check("stall_flush2", {31'd0, s_flush}, 32'd0);
    idle_cyc(0);
    check("pend_flush", {31'd0, s_flush}, 32'd1);
    idle_cyc(0);
    check("pend_pc", s_pc, 32'h88);

    // single step with a stall in the first STEP cycle
    do_reset();
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20);
    idle_cyc(0);
    check("step_idle_pc", s_pc, 32'h20);
    cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_cyc(1);
    check("step_st1", {30'd0, s_state}, 32'd2);
    idle_cyc(0);
    check("step_st2", {30'd0, s_state}, 32'd2);
    idle_cyc(0);
    check("step_done", {30'd0, s_state}, 32'd0);
    check("step_pc", s_pc, 32'h24);
    idle_cyc(0);
    check("step_frozen", s_pc, 32'h24);

    // halt beats branch; start ignored in HALT; async reset out of HALT
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 1, 32'h500, 0, 0, 0, 0);
    check("halt_noflush", {31'd0, s_flush}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("halt_state", {30'd0, s_state}, 32'd3);
    check("halt_pc", s_pc, 32'h24);
    check("halt_valid", {31'd0, s_valid}, 32'd0);
    idle_cyc(0);
    check("halt_stays", {30'd0, s_state}, 32'd3);
    do_reset();

    // wrap of pc4
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    idle_cyc(0);
    check("wrap_pc", s_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", pc4, 32'h0);
    idle_cyc(0);
    check("wrap_next", s_pc, 32'h0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (m_state == 3 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 60) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) == 0, $urandom,
            $urandom_range(0, 4) == 0, $urandom,
            $urandom_range(0, 4) == 0, $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
